gen_sequencer: RTL and testbench

GEN_SEQUENCER -- requirements
Module: gen_sequencer

---
 rtl/gen_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_gen_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gen_sequencer.sv
// Generation sequencer: drives a grid solver through seeded attempts, then
// streams the solved grid cell by cell and reports the outcome to the host.
module gen_sequencer #(
  parameter int unsigned GRID_ORD   = 3,
  parameter int unsigned LFSR_WIDTH = 8,
  parameter int unsigned MAX_TRIES  = 4,
  parameter int unsigned TIMEOUT    = 65535,
  localparam int unsigned GRID_LEN  = GRID_ORD * GRID_ORD,
  localparam int unsigned GRID_AREA = GRID_LEN * GRID_LEN,
  localparam int unsigned VW        = (GRID_LEN > 1) ? $clog2(GRID_LEN) : 1,
  localparam int unsigned AW        = (GRID_AREA > 1) ? $clog2(GRID_AREA) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmd_valid,
  input  logic [LFSR_WIDTH-1:0] cmd_seed,
  output logic                  cmd_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_ok,
  output logic [7:0]            rsp_tries,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [VW-1:0]         out_data,
  output logic                  out_last,
  output logic                  out_err,
  output logic                  grid_reset,
  output logic                  grid_rq_start,
  output logic [LFSR_WIDTH-1:0] grid_seed,
  input  logic                  grid_done,
  input  logic                  grid_success,
  output logic [AW-1:0]         grid_rdaddr,
  input  logic [GRID_LEN-1:0]   grid_rddata
);

  localparam int unsigned LW = LFSR_WIDTH;
  localparam int unsigned TW = 8;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRST,
    S_RUN,
    S_READ,
    S_RESP
  } state_t;

  state_t          state, state_nxt;
  logic [LW-1:0]   base_seed, base_seed_nxt;
  logic [TW-1:0]   tries, tries_nxt;
  logic [CW-1:0]   run_cnt, run_cnt_nxt;
  logic            run_fail;

  logic            cmd_ready_nxt;
  logic            rsp_valid_nxt;
  logic            rsp_ok_nxt;
  logic [TW-1:0]   rsp_tries_nxt;
  logic            out_valid_nxt;
  logic            out_last_nxt;
  logic            grid_reset_nxt;
  logic            grid_rq_start_nxt;
  logic [LW-1:0]   grid_seed_nxt;
  logic [AW-1:0]   grid_rdaddr_nxt;

  logic [VW-1:0]   low_idx;
  logic            found;
  logic            one_hot;

  // Seed for an attempt; zero would lock up the solver LFSR, so it maps to 1.
  function automatic logic [LW-1:0] attempt_seed(input logic [LW-1:0] base,
                                                 input logic [TW-1:0] idx);
    logic [LW-1:0] sum;
    sum = base + LW'(idx);
    return (sum == '0) ? LW'(1) : sum;
  endfunction

  always_comb begin
    state_nxt         = state;
    base_seed_nxt     = base_seed;
    tries_nxt         = tries;
    run_cnt_nxt       = run_cnt;
    run_fail          = 1'b0;
    cmd_ready_nxt     = cmd_ready;
    rsp_valid_nxt     = rsp_valid;
    rsp_ok_nxt        = rsp_ok;
    rsp_tries_nxt     = rsp_tries;
    out_valid_nxt     = out_valid;
    out_last_nxt      = out_last;
    grid_reset_nxt    = 1'b0;
    grid_rq_start_nxt = grid_rq_start;
    grid_seed_nxt     = grid_seed;
    grid_rdaddr_nxt   = grid_rdaddr;

    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          state_nxt      = S_GRST;
          base_seed_nxt  = cmd_seed;
          tries_nxt      = TW'(1);
          grid_seed_nxt  = attempt_seed(cmd_seed, '0);
          grid_reset_nxt = 1'b1;
          cmd_ready_nxt  = 1'b0;
        end
      end

      S_GRST: begin
        state_nxt         = S_RUN;
        grid_rq_start_nxt = 1'b1;
        run_cnt_nxt       = '0;
      end

      S_RUN: begin
        // A done in the final budget cycle takes precedence over the timeout.
        if (grid_done) begin
          grid_rq_start_nxt = 1'b0;
          if (grid_success) begin
            state_nxt       = S_READ;
            out_valid_nxt   = 1'b1;
            grid_rdaddr_nxt = '0;
            out_last_nxt    = (GRID_AREA == 1);
          end else begin
            run_fail = 1'b1;
          end
        end else if (run_cnt == CW'(TIMEOUT - 1)) begin
          grid_rq_start_nxt = 1'b0;
          run_fail          = 1'b1;
        end else begin
          run_cnt_nxt = run_cnt + CW'(1);
        end

        if (run_fail) begin
          if (tries < TW'(MAX_TRIES)) begin
            state_nxt      = S_GRST;
            grid_reset_nxt = 1'b1;
            grid_seed_nxt  = attempt_seed(base_seed, tries);
            tries_nxt      = tries + TW'(1);
          end else begin
            state_nxt     = S_RESP;
            rsp_valid_nxt = 1'b1;
            rsp_ok_nxt    = 1'b0;
            rsp_tries_nxt = tries;
          end
        end
      end

      S_READ: begin
        if (out_ready) begin
          if (grid_rdaddr == AW'(GRID_AREA - 1)) begin
            state_nxt       = S_RESP;
            out_valid_nxt   = 1'b0;
            out_last_nxt    = 1'b0;
            grid_rdaddr_nxt = '0;
            rsp_valid_nxt   = 1'b1;
            rsp_ok_nxt      = 1'b1;
            rsp_tries_nxt   = tries;
          end else begin
            grid_rdaddr_nxt = grid_rdaddr + AW'(1);
            out_last_nxt    = ((grid_rdaddr + AW'(1)) == AW'(GRID_AREA - 1));
          end
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          state_nxt     = S_IDLE;
          rsp_valid_nxt = 1'b0;
          cmd_ready_nxt = 1'b1;
        end
      end

      default: begin
        state_nxt     = S_IDLE;
        cmd_ready_nxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= S_IDLE;
      base_seed     <= '0;
      tries         <= '0;
      run_cnt       <= '0;
      cmd_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_ok        <= 1'b0;
      rsp_tries     <= '0;
      out_valid     <= 1'b0;
      out_last      <= 1'b0;
      grid_reset    <= 1'b1;
      grid_rq_start <= 1'b0;
      grid_seed     <= '0;
      grid_rdaddr   <= '0;
    end else begin
      state         <= state_nxt;
      base_seed     <= base_seed_nxt;
      tries         <= tries_nxt;
      run_cnt       <= run_cnt_nxt;
      cmd_ready     <= cmd_ready_nxt;
      rsp_valid     <= rsp_valid_nxt;
      rsp_ok        <= rsp_ok_nxt;
      rsp_tries     <= rsp_tries_nxt;
      out_valid     <= out_valid_nxt;
      out_last      <= out_last_nxt;
      grid_reset    <= grid_reset_nxt;
      grid_rq_start <= grid_rq_start_nxt;
      grid_seed     <= grid_seed_nxt;
      grid_rdaddr   <= grid_rdaddr_nxt;
    end
  end

  // Cell decode straight from the read port: lowest set bit plus a one-hot check.
  always_comb begin
    low_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < int'(GRID_LEN); i++) begin
      if (!found && grid_rddata[i]) begin
        low_idx = VW'(i);
        found   = 1'b1;
      end
    end
  end

  assign one_hot  = found && ((grid_rddata & (grid_rddata - GRID_LEN'(1))) == '0);
  assign out_err  = !one_hot;
  assign out_data = one_hot ? low_idx : '0;

endmodule

// File: tb/tb_gen_sequencer.sv
// Scoreboard bench for gen_sequencer: a behavioural grid model answers the
// sequencer, stimulus queues expected seeds/run lengths/beats/responses.
module tb_gen_sequencer;

  localparam int unsigned LEN  = 9;
  localparam int unsigned AREA = 81;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [7:0]  cmd_seed = '0;
  logic        cmd_ready;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic        rsp_ok;
  logic [7:0]  rsp_tries;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [3:0]  out_data;
  logic        out_last;
  logic        out_err;
  logic        grid_reset;
  logic        grid_rq_start;
  logic [7:0]  grid_seed;
  logic        grid_done = 1'b0;
  logic        grid_success = 1'b0;
  logic [6:0]  grid_rdaddr;
  logic [8:0]  grid_rddata;

  always #5 clock = ~clock;

  gen_sequencer #(.GRID_ORD(3), .LFSR_WIDTH(8), .MAX_TRIES(4), .TIMEOUT(100)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_seed(cmd_seed), .cmd_ready(cmd_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_ok(rsp_ok), .rsp_tries(rsp_tries),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_err(out_err),
    .grid_reset(grid_reset), .grid_rq_start(grid_rq_start), .grid_seed(grid_seed),
    .grid_done(grid_done), .grid_success(grid_success),
    .grid_rdaddr(grid_rdaddr), .grid_rddata(grid_rddata)
  );

  typedef struct packed { logic [3:0] d; logic l; logic e; } beat_t;
  typedef struct packed { logic ok; logic [7:0] tries; } rsp_t;

  int errors = 0;
  int checks = 0;

  logic [7:0] seed_q[$];
  int         run_q[$];
  beat_t      beat_q[$];
  rsp_t       rsp_q[$];

  int   plan_done[8];
  logic plan_succ[8];
  logic [8:0] raw[AREA];
  int   val[AREA];
  logic bad[AREA];

  assign grid_rddata = raw[grid_rdaddr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Grid model: counts attempts and RUN cycles, raises done per the plan.
  int attempt = 0;
  int run_cyc = 0;
  always @(posedge clock) begin
    #1;
    if (cmd_ready) attempt = 0;
    else if (grid_reset) begin
      attempt++;
      run_cyc = 0;
    end else if (grid_rq_start) run_cyc++;
    if (grid_rq_start && attempt >= 1 && attempt <= 8 &&
        plan_done[attempt-1] != 0 && run_cyc == plan_done[attempt-1]) begin
      grid_done    = 1'b1;
      grid_success = plan_succ[attempt-1];
    end else begin
      grid_done    = 1'b0;
      grid_success = 1'b0;
    end
  end

  // Monitor: compares every presented output against the scoreboard queues.
  int         run_len = 0;
  int         beats_acc = 0;
  logic [7:0] cur_seed = '0;
  always @(negedge clock) begin
    if (!reset) begin
      if (grid_reset && !cmd_ready) begin
        if (seed_q.size() == 0) chk("grst_unexpected", 32'(grid_reset), 0);
        else begin
          cur_seed = seed_q.pop_front();
          chk("grid_seed", 32'(grid_seed), 32'(cur_seed));
        end
      end
      if (grid_rq_start) begin
        run_len++;
        chk("seed_stable_in_run", 32'(grid_seed), 32'(cur_seed));
      end else if (run_len > 0) begin
        if (run_q.size() == 0) chk("run_unexpected", 32'(run_len), 0);
        else chk("run_len", 32'(run_len), 32'(run_q.pop_front()));
        run_len = 0;
      end
      if (out_valid) begin
        if (beat_q.size() == 0) chk("beat_unexpected", 32'(out_valid), 0);
        else begin
          chk($sformatf("beat%0d_data", beats_acc), 32'(out_data), 32'(beat_q[0].d));
          chk($sformatf("beat%0d_last", beats_acc), 32'(out_last), 32'(beat_q[0].l));
          chk($sformatf("beat%0d_err", beats_acc),  32'(out_err),  32'(beat_q[0].e));
          if (out_ready) begin
            void'(beat_q.pop_front());
            beats_acc++;
          end
        end
      end
      if (rsp_valid) begin
        if (rsp_q.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 0);
        else begin
          chk("rsp_ok", 32'(rsp_ok), 32'(rsp_q[0].ok));
          chk("rsp_tries", 32'(rsp_tries), 32'(rsp_q[0].tries));
          if (rsp_ready) void'(rsp_q.pop_front());
        end
      end
    end
  end

  task automatic load_mem();
    for (int i = 0; i < int'(AREA); i++) begin
      val[i] = (i * 4 + i / 9) % 9;
      raw[i] = 9'(1) << val[i];
      bad[i] = 1'b0;
    end
  endtask

  task automatic set_plan(input int d0, input logic s0, input int d1, input logic s1,
                          input int d2, input logic s2, input int d3, input logic s3);
    plan_done[0] = d0; plan_succ[0] = s0;
    plan_done[1] = d1; plan_succ[1] = s1;
    plan_done[2] = d2; plan_succ[2] = s2;
    plan_done[3] = d3; plan_succ[3] = s3;
  endtask

  task automatic push_stream();
    beat_t b;
    for (int i = 0; i < int'(AREA); i++) begin
      b.d = bad[i] ? 4'd0 : 4'(val[i]);
      b.l = (i == int'(AREA) - 1);
      b.e = bad[i];
      beat_q.push_back(b);
    end
  endtask

  task automatic push_rsp(input logic ok, input logic [7:0] t);
    rsp_t r;
    r.ok = ok;
    r.tries = t;
    rsp_q.push_back(r);
  endtask

  task automatic issue(input logic [7:0] s);
    @(posedge clock); #1;
    chk("cmd_ready_idle", 32'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_seed  = s;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget, input bit rnd, input int rsp_delay);
    int n = 0;
    int seen = 0;
    rsp_ready = (rsp_delay == 0);
    while ((beat_q.size() != 0 || rsp_q.size() != 0) && n < budget) begin
      @(posedge clock); #1;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      if (rsp_valid) seen++;
      rsp_ready = (seen >= rsp_delay);
      n++;
    end
    out_ready = 1'b1;
    rsp_ready = 1'b1;
    chk({tag, "_drained"}, 32'(beat_q.size() + rsp_q.size()), 0);
    repeat (2) @(posedge clock);
    #1;
    chk({tag, "_seeds_used"}, 32'(seed_q.size() + run_q.size()), 0);
    chk({tag, "_back_idle"}, 32'(cmd_ready), 1);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_rsp_ok"}, 32'(rsp_ok), 0);
    chk({tag, "_rsp_tries"}, 32'(rsp_tries), 0);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_out_last"}, 32'(out_last), 0);
    chk({tag, "_grid_reset"}, 32'(grid_reset), 1);
    chk({tag, "_grid_rq_start"}, 32'(grid_rq_start), 0);
    chk({tag, "_grid_seed"}, 32'(grid_seed), 0);
    chk({tag, "_grid_rdaddr"}, 32'(grid_rdaddr), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    load_mem();
    set_plan(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clock);
    #1;
    chk_reset_values("por");
    reset = 1'b0;

    // First-attempt success, seed passed through unchanged.
    set_plan(5, 1, 0, 0, 0, 0, 0, 0);
    seed_q.push_back(8'h5A); run_q.push_back(5);
    push_stream(); push_rsp(1'b1, 8'd1);
    issue(8'h5A);
    wait_idle("t1", 400, 1'b0, 0);

    // Three failures then success; a command during RUN must be dropped.
    set_plan(3, 0, 4, 0, 2, 0, 6, 1);
    seed_q.push_back(8'h10); seed_q.push_back(8'h11);
    seed_q.push_back(8'h12); seed_q.push_back(8'h13);
    run_q.push_back(3); run_q.push_back(4); run_q.push_back(2); run_q.push_back(6);
    push_stream(); push_rsp(1'b1, 8'd4);
    issue(8'h10);
    repeat (3) @(posedge clock);
    #1; cmd_valid = 1'b1; cmd_seed = 8'h77;
    @(posedge clock); #1; cmd_valid = 1'b0;
    wait_idle("t2", 500, 1'b0, 0);

    // All attempts fail; seed wraps and zero becomes one; response held.
    set_plan(2, 0, 2, 0, 2, 0, 2, 0);
    seed_q.push_back(8'hFF); seed_q.push_back(8'h01);
    seed_q.push_back(8'h01); seed_q.push_back(8'h02);
    for (int i = 0; i < 4; i++) run_q.push_back(2);
    push_rsp(1'b0, 8'd4);
    issue(8'hFF);
    wait_idle("t3", 200, 1'b0, 4);

    // Solver never finishes: each attempt times out after 100 RUN cycles.
    set_plan(0, 0, 0, 0, 0, 0, 0, 0);
    seed_q.push_back(8'h30); seed_q.push_back(8'h31);
    seed_q.push_back(8'h32); seed_q.push_back(8'h33);
    for (int i = 0; i < 4; i++) run_q.push_back(100);
    push_rsp(1'b0, 8'd4);
    issue(8'h30);
    wait_idle("t4", 600, 1'b0, 0);

    // Done with success on the timeout cycle wins; multi-bit cell flags error.
    raw[20] = 9'b000100100; bad[20] = 1'b1;
    set_plan(100, 1, 0, 0, 0, 0, 0, 0);
    seed_q.push_back(8'h40); run_q.push_back(100);
    push_stream(); push_rsp(1'b1, 8'd1);
    issue(8'h40);
    wait_idle("t5", 400, 1'b0, 0);
    load_mem();

    // Random back-pressure with an empty cell at index 5.
    raw[5] = 9'b0; bad[5] = 1'b1;
    set_plan(1, 1, 0, 0, 0, 0, 0, 0);
    seed_q.push_back(8'h21); run_q.push_back(1);
    push_stream(); push_rsp(1'b1, 8'd1);
    issue(8'h21);
    wait_idle("t6", 2000, 1'b1, 0);
    load_mem();

    // Reset mid-stream while beat 40 is presented.
    set_plan(3, 1, 0, 0, 0, 0, 0, 0);
    seed_q.push_back(8'h33); run_q.push_back(3);
    push_stream(); push_rsp(1'b1, 8'd1);
    base = beats_acc;
    issue(8'h33);
    for (int n = 0; n < 500 && (beats_acc - base) < 39; n++) begin
      @(posedge clock); #1;
    end
    chk("t7_reached_beat40", 32'(beats_acc - base), 39);
    chk("t7_beat40_valid", 32'(out_valid), 1);
    reset = 1'b1;
    beat_q.delete();
    rsp_q.delete();
    @(posedge clock); #1;
    chk_reset_values("t7_abort");
    reset = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    chk("t7_no_rsp", 32'(rsp_valid), 0);

    // A fresh command after the abort runs normally.
    set_plan(2, 1, 0, 0, 0, 0, 0, 0);
    seed_q.push_back(8'h07); run_q.push_back(2);
    push_stream(); push_rsp(1'b1, 8'd1);
    issue(8'h07);
    wait_idle("t8", 400, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
